// File: rtl/sap_pkg.sv
// Shared constants for the SAP CPU: control-word bit positions, idle control word,
// and opcodes. The control block imports the same package.
package sap_pkg;
    localparam int CTRL_W = 15;

    localparam int SIG_PC_INC     = 14;
    localparam int SIG_PC_EN      = 13;
    localparam int SIG_PC_LOAD    = 12;
    localparam int SIG_MAR_LOAD_N = 11;
    localparam int SIG_MDR_LOAD_N = 10;
    localparam int SIG_RAM_EN_N   = 9;
    localparam int SIG_RAM_LOAD_N = 8;
    localparam int SIG_IR_LOAD_N  = 7;
    localparam int SIG_IR_EN_N    = 6;
    localparam int SIG_A_LOAD_N   = 5;
    localparam int SIG_A_EN       = 4;
    localparam int SIG_SUB        = 3;
    localparam int SIG_ALU_EN     = 2;
    localparam int SIG_B_LOAD_N   = 1;
    localparam int SIG_OUT_LOAD_N = 0;

    // Every active-low bit high, every active-high bit low: nothing drives, nothing loads.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

    typedef enum logic [3:0] {
        OP_HLT = 4'h0,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_LDA = 4'h4,
        OP_OUT = 4'h5,
        OP_STA = 4'h6,
        OP_JMP = 4'h7
    } opcode_e;
endpackage

// File: rtl/sap_datapath_if.sv
// Control/program/observation bundle between the SAP controller (master) and the datapath (slave).
interface sap_datapath_if
    import sap_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [CTRL_W-1:0] ctrl;
    logic              prog_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] out_val;
    logic [DATA_W-1:0] bus_mon;
    logic              bus_conflict;

    modport master (
        output ctrl, prog_en, prog_we, prog_addr, prog_data,
        input  opcode, out_val, bus_mon, bus_conflict
    );
    modport slave (
        input  ctrl, prog_en, prog_we, prog_addr, prog_data,
        output opcode, out_val, bus_mon, bus_conflict
    );
endinterface

// File: rtl/sap_ram.sv
// Program/data RAM: asynchronous read, one synchronous write port shared between
// the datapath (MDR -> RAM[MAR]) and the program loader, selected by prog_en.
module sap_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        we    = dp_we;
        waddr = dp_addr;
        wdata = dp_data;
        if (prog_en) begin
            we    = prog_we;
            waddr = prog_addr;
            wdata = prog_data;
        end
    end

    // Contents survive reset on purpose; the loaded program must outlive it.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/sap_datapath.sv
// SAP-1 register-transfer datapath: one shared bus, PC/MAR/MDR/IR/A/B/OUT registers,
// adder/subtractor and RAM, all steered by the 15-bit control word.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sap_datapath_if.slave  dp
);
    localparam int PAD_W = DATA_W - ADDR_W;

    logic [CTRL_W-1:0] c;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic [DATA_W-1:0] ram_rdata, alu, bus;
    logic [4:0]        drv;
    logic              conflict;

    // Program mode masks the control word so the datapath freezes.
    assign c = dp.prog_en ? CTRL_IDLE : dp.ctrl;

    always_comb begin
        alu = c[SIG_SUB] ? a_q + ~b_q + DATA_W'(1) : a_q + b_q;
        drv = {c[SIG_PC_EN], ~c[SIG_RAM_EN_N], ~c[SIG_IR_EN_N], c[SIG_A_EN], c[SIG_ALU_EN]};
        // More than one bit set in drv means contention; the bus then reads zero.
        conflict = |(drv & (drv - 5'd1));
        bus = ({DATA_W{drv[4]}} & {{PAD_W{1'b0}}, pc_q})
            | ({DATA_W{drv[3]}} & ram_rdata)
            | ({DATA_W{drv[2]}} & {{PAD_W{1'b0}}, ir_q[ADDR_W-1:0]})
            | ({DATA_W{drv[1]}} & a_q)
            | ({DATA_W{drv[0]}} & alu);
        if (conflict) bus = '0;
    end

    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        if (c[SIG_PC_LOAD])       pc_d = bus[ADDR_W-1:0];
        else if (c[SIG_PC_INC])   pc_d = pc_q + 1'b1;
        if (!c[SIG_MAR_LOAD_N])   mar_d = bus[ADDR_W-1:0];
        if (!c[SIG_MDR_LOAD_N])   mdr_d = bus;
        if (!c[SIG_IR_LOAD_N])    ir_d  = bus;
        if (!c[SIG_A_LOAD_N])     a_d   = bus;
        if (!c[SIG_B_LOAD_N])     b_d   = bus;
        if (!c[SIG_OUT_LOAD_N])   out_d = bus;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
        end
    end

    sap_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk       (clk),
        .prog_en   (dp.prog_en),
        .prog_we   (dp.prog_we),
        .prog_addr (dp.prog_addr),
        .prog_data (dp.prog_data),
        .dp_we     (~c[SIG_RAM_LOAD_N] & rst_n),
        .dp_addr   (mar_q),
        .dp_data   (mdr_q),
        .rd_addr   (mar_q),
        .rd_data   (ram_rdata)
    );

    assign dp.opcode       = ir_q[DATA_W-1 -: 4];
    assign dp.out_val      = out_q;
    assign dp.bus_mon      = bus;
    assign dp.bus_conflict = conflict;
endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: a register-level reference model checked every
// cycle, plus hand-computed bus/opcode/output expectations along a short program.
module tb_sap_datapath;
    import sap_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sap_datapath_if #(.ADDR_W(4), .DATA_W(8)) dpif ();
    sap_datapath #(.ADDR_W(4), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .dp(dpif));

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_mdr, m_ir, m_a, m_b, m_out;
    logic [7:0] m_ram [16];
    bit         m_ram_ok [16];
    bit         m_live = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [14:0] sig(input int i);
        return 15'(1) << i;
    endfunction

    // Bus value from the model: count the enabled drivers; two or more reads zero.
    function automatic void model_bus(input logic [14:0] ctl, input bit pe,
                                      output logic [7:0] v, output bit conf, output bit known);
        int n = 0;
        v = 8'h00;
        known = 1'b1;
        if (!pe) begin
            if (ctl[SIG_PC_EN])     begin n++; v = {4'h0, m_pc}; end
            if (!ctl[SIG_RAM_EN_N]) begin n++; v = m_ram[m_mar]; known = m_ram_ok[m_mar]; end
            if (!ctl[SIG_IR_EN_N])  begin n++; v = {4'h0, m_ir[3:0]}; end
            if (ctl[SIG_A_EN])      begin n++; v = m_a; end
            if (ctl[SIG_ALU_EN]) begin
                n++;
                v = ctl[SIG_SUB] ? 8'(int'(m_a) - int'(m_b)) : 8'(int'(m_a) + int'(m_b));
            end
        end
        conf = (n > 1);
        if (conf) begin v = 8'h00; known = 1'b1; end
    endfunction

    always @(posedge clk) begin
        logic [7:0] v;
        bit conf, known;
        model_bus(dpif.ctrl, dpif.prog_en, v, conf, known);
        if (dpif.prog_en && dpif.prog_we) begin
            m_ram[dpif.prog_addr]    <= dpif.prog_data;
            m_ram_ok[dpif.prog_addr] <= 1'b1;
        end else if (rst_n && !dpif.prog_en && !dpif.ctrl[SIG_RAM_LOAD_N]) begin
            m_ram[m_mar]    <= m_mdr;
            m_ram_ok[m_mar] <= m_live;
        end
        if (!rst_n) begin
            m_pc <= 4'h0; m_mar <= 4'h0; m_mdr <= 8'h00; m_ir <= 8'h00;
            m_a <= 8'h00; m_b <= 8'h00; m_out <= 8'h00; m_live <= 1'b1;
        end else if (!dpif.prog_en) begin
            if (dpif.ctrl[SIG_PC_LOAD])      m_pc <= v[3:0];
            else if (dpif.ctrl[SIG_PC_INC])  m_pc <= 4'((int'(m_pc) + 1) % 16);
            if (!dpif.ctrl[SIG_MAR_LOAD_N])  m_mar <= v[3:0];
            if (!dpif.ctrl[SIG_MDR_LOAD_N])  m_mdr <= v;
            if (!dpif.ctrl[SIG_IR_LOAD_N])   m_ir  <= v;
            if (!dpif.ctrl[SIG_A_LOAD_N])    m_a   <= v;
            if (!dpif.ctrl[SIG_B_LOAD_N])    m_b   <= v;
            if (!dpif.ctrl[SIG_OUT_LOAD_N])  m_out <= v;
        end
    end

    // Compare process: every cycle once the model has been reset.
    always @(negedge clk) begin
        logic [7:0] v;
        bit conf, known;
        if (m_live) begin
            model_bus(dpif.ctrl, dpif.prog_en, v, conf, known);
            if (known) check("model bus_mon", dpif.bus_mon, v);
            check("model bus_conflict", {7'h0, dpif.bus_conflict}, {7'h0, conf});
            check("model opcode", {4'h0, dpif.opcode}, {4'h0, m_ir[7:4]});
            check("model out_val", dpif.out_val, m_out);
        end
    end

    task automatic drive(input logic [14:0] act);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dpif.prog_en = 1'b0;
        dpif.prog_we = 1'b0;
        dpif.ctrl = CTRL_IDLE ^ act;
        @(negedge clk); #1;
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        dpif.prog_en = 1'b1;
        dpif.prog_we = 1'b1;
        dpif.prog_addr = addr;
        dpif.prog_data = data;
        dpif.ctrl = CTRL_IDLE;
        @(negedge clk); #1;
    endtask

    task automatic freeze(input logic [14:0] act);
        @(posedge clk); #1;
        dpif.prog_en = 1'b1;
        dpif.prog_we = 1'b0;
        dpif.ctrl = CTRL_IDLE ^ act;
        @(negedge clk); #1;
    endtask

    task automatic pulse_reset(input logic [14:0] act);
        @(posedge clk); #1;
        rst_n = 1'b0;
        dpif.prog_en = 1'b0;
        dpif.ctrl = CTRL_IDLE ^ act;
        @(negedge clk); #1;
    endtask

    task automatic bus_is(input string name, input logic [7:0] exp);
        check(name, dpif.bus_mon, exp);
    endtask

    localparam logic [14:0] FETCH_MAR = 15'h2800;  // E_P | ~L_MA

    initial begin
        logic [14:0] ep, ram_rd, ld_mar, ld_a, ld_b, ld_ir, ld_out, inc, ea, eu, sub;
        ep = sig(SIG_PC_EN);       ram_rd = sig(SIG_RAM_EN_N); ld_mar = sig(SIG_MAR_LOAD_N);
        ld_a = sig(SIG_A_LOAD_N);  ld_b = sig(SIG_B_LOAD_N);   ld_ir = sig(SIG_IR_LOAD_N);
        ld_out = sig(SIG_OUT_LOAD_N); inc = sig(SIG_PC_INC);   ea = sig(SIG_A_EN);
        eu = sig(SIG_ALU_EN);      sub = sig(SIG_SUB);

        dpif.ctrl = CTRL_IDLE; dpif.prog_en = 1'b0; dpif.prog_we = 1'b0;
        dpif.prog_addr = 4'h0; dpif.prog_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset out_val", dpif.out_val, 8'h00);
        check("reset opcode", {4'h0, dpif.opcode}, 8'h00);

        prog(4'h0, 8'h4E); prog(4'h1, 8'h03); prog(4'h2, 8'h05); prog(4'h3, 8'h5A);
        prog(4'h4, 8'h6F); prog(4'h5, 8'h73); prog(4'hF, 8'h11);

        // Fetch of LDA E
        drive(FETCH_MAR);              bus_is("fetch pc on bus", 8'h00);
        drive(ram_rd | ld_ir | inc);   bus_is("fetch ram[0]", 8'h4E);
        drive(ep);                     bus_is("pc after fetch", 8'h01);
        check("opcode LDA", {4'h0, dpif.opcode}, 8'h04);

        // A=03, B=05 then add / subtract
        drive(ep | ld_mar); drive(ram_rd | ld_a | inc); bus_is("load A", 8'h03);
        drive(ep | ld_mar); drive(ram_rd | ld_b | inc); bus_is("load B", 8'h05);
        drive(eu);                     bus_is("alu add", 8'h08);
        drive(eu | sub | ld_a);        bus_is("alu sub", 8'hFE);
        drive(ea);                     bus_is("A after sub", 8'hFE);

        // STA F with A=5A; same-cycle read during write sees old data
        drive(ep | ld_mar); drive(ram_rd | ld_a | inc); bus_is("load A 5A", 8'h5A);
        drive(ep | ld_mar); drive(ram_rd | ld_ir | inc); bus_is("fetch STA", 8'h6F);
        drive(sig(SIG_IR_EN_N) | ld_mar); bus_is("ir operand", 8'h0F);
        check("opcode STA", {4'h0, dpif.opcode}, 8'h06);
        drive(ea | sig(SIG_MDR_LOAD_N)); bus_is("A to MDR", 8'h5A);
        drive(sig(SIG_RAM_LOAD_N) | ram_rd | ld_b); bus_is("read during write", 8'h11);
        drive(ram_rd | ld_b);          bus_is("read after write", 8'h5A);
        drive(eu);                     bus_is("A+B 5A+5A", 8'hB4);

        // JMP 3 with C_P asserted too: load wins; then wrap 15 -> 0
        drive(ep | ld_mar); drive(ram_rd | ld_ir | inc); bus_is("fetch JMP", 8'h73);
        drive(sig(SIG_IR_EN_N) | sig(SIG_PC_LOAD) | inc); bus_is("jmp operand", 8'h03);
        drive(ep);                     bus_is("pc after jmp", 8'h03);
        repeat (12) drive(inc);
        drive(ep);                     bus_is("pc at 15", 8'h0F);
        drive(inc);
        drive(ep);                     bus_is("pc wrap", 8'h00);

        // Contention
        drive(ea | ld_out);
        drive(ep);                     check("out loaded", dpif.out_val, 8'h5A);
        drive(ea | eu | ld_out);       bus_is("conflict bus", 8'h00);
        check("conflict flag", {7'h0, dpif.bus_conflict}, 8'h01);
        drive(ep);                     check("out during conflict", dpif.out_val, 8'h00);

        // Program-mode freeze
        drive(ea | ld_out);
        freeze(15'h7FFF);              bus_is("frozen bus", 8'h00);
        check("frozen conflict", {7'h0, dpif.bus_conflict}, 8'h00);
        drive(ea);                     bus_is("A held", 8'h5A);
        check("out held", dpif.out_val, 8'h5A);
        drive(ep);                     bus_is("pc held", 8'h00);
        check("opcode held", {4'h0, dpif.opcode}, 8'h07);

        // Reset mid-instruction; RAM survives
        pulse_reset(ea | ld_out | inc);
        drive(ea);                     bus_is("A after reset", 8'h00);
        check("out after reset", dpif.out_val, 8'h00);
        check("opcode after reset", {4'h0, dpif.opcode}, 8'h00);
        drive(ep);                     bus_is("pc after reset", 8'h00);
        drive(ram_rd);                 bus_is("ram kept", 8'h4E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
